// File: rtl/ctrl_pkg.sv
// Shared decode definitions: RV32 opcodes, ALU/writeback encodings and the
// control bundle carried from decode into the ID/EX register.
package ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,  ALU_SLL  = 5'd1,  ALU_SLT    = 5'd2,  ALU_SLTU  = 5'd3,
    ALU_XOR  = 5'd4,  ALU_SRL  = 5'd5,  ALU_SRA    = 5'd6,  ALU_OR    = 5'd7,
    ALU_AND  = 5'd8,  ALU_SUB  = 5'd9,  ALU_MUL    = 5'd10, ALU_MULH  = 5'd11,
    ALU_MULHSU = 5'd12, ALU_MULHU = 5'd13, ALU_DIV = 5'd14, ALU_DIVU  = 5'd15,
    ALU_REM  = 5'd16, ALU_REMU = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef struct packed {
    alu_op_e    alu_op;
    logic [2:0] mask;
    logic [2:0] br_type;
    logic       reg_wr;
    logic       sel_a;
    logic       sel_b;
    logic       rd_en;
    logic       wr_en;
    wb_sel_e    wb_sel;
    logic       is_jalr;
    logic       illegal;
    logic [4:0] rd_addr;
    logic [4:0] rs1_addr;
    logic [4:0] rs2_addr;
  } ctrl_t;

  // alt selects sub/sra, i.e. instruction[30] on the shared funct3 slots
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic is_load(input ctrl_t c);
    return c.rd_en;
  endfunction

  function automatic logic is_div(input ctrl_t c);
    return (c.alu_op >= ALU_DIV) && (c.alu_op <= ALU_REMU);
  endfunction

endpackage

// File: rtl/decode_ctrl_pipe_if.sv
// Handshake and decoded-control bundle between fetch, the decode pipe and execute.
interface decode_ctrl_pipe_if #(parameter int ALU_OP_W = 5) ();
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         instruction;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [ALU_OP_W-1:0] alu_op;
  logic [2:0]          mask;
  logic [2:0]          br_type;
  logic                reg_wr;
  logic                sel_A;
  logic                sel_B;
  logic                rd_en;
  logic                wr_en;
  logic [1:0]          wb_sel;
  logic                is_jalr;
  logic [4:0]          rd_addr;
  logic [4:0]          rs1_addr;
  logic [4:0]          rs2_addr;
  logic                illegal;

  modport master (
    output in_valid, instruction, flush, out_ready,
    input  in_ready, out_valid, alu_op, mask, br_type, reg_wr, sel_A, sel_B,
           rd_en, wr_en, wb_sel, is_jalr, rd_addr, rs1_addr, rs2_addr, illegal
  );

  modport slave (
    input  in_valid, instruction, flush, out_ready,
    output in_ready, out_valid, alu_op, mask, br_type, reg_wr, sel_A, sel_B,
           rd_en, wr_en, wb_sel, is_jalr, rd_addr, rs1_addr, rs2_addr, illegal
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational RV32I(+M) decoder producing the control bundle and the
// source-register usage flags needed for load-use detection.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit EN_M = 1'b1
) (
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        uses_rs1_o,
  output logic        uses_rs2_o
);

  logic [6:0] opc_s;
  logic [6:0] f7_s;
  logic [2:0] f3_s;
  ctrl_t      raw_s;
  logic       ill_s;
  logic       u1_s;
  logic       u2_s;

  assign opc_s = instr_i[6:0];
  assign f3_s  = instr_i[14:12];
  assign f7_s  = instr_i[31:25];

  // Per-opcode decode before the illegal override
  always_comb begin
    raw_s          = '0;
    ill_s          = 1'b0;
    u1_s           = 1'b0;
    u2_s           = 1'b0;
    raw_s.rd_addr  = instr_i[11:7];
    raw_s.rs1_addr = instr_i[19:15];
    raw_s.rs2_addr = instr_i[24:20];
    case (opc_s)
      OPC_OP: begin
        raw_s.reg_wr = 1'b1;
        raw_s.sel_a  = 1'b1;
        u1_s         = 1'b1;
        u2_s         = 1'b1;
        if (f7_s == 7'b0000000) begin
          raw_s.alu_op = alu_from_f3(f3_s, 1'b0);
        end else if (f7_s == 7'b0100000 && (f3_s == 3'b000 || f3_s == 3'b101)) begin
          raw_s.alu_op = alu_from_f3(f3_s, 1'b1);
        end else if (f7_s == 7'b0000001 && EN_M) begin
          raw_s.alu_op = alu_op_e'(5'd10 + {2'b00, f3_s});
        end else begin
          ill_s = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        raw_s.reg_wr = 1'b1;
        raw_s.sel_a  = 1'b1;
        raw_s.sel_b  = 1'b1;
        u1_s         = 1'b1;
        if (f3_s == 3'b001) begin
          raw_s.alu_op = ALU_SLL;
          ill_s        = (f7_s != 7'b0000000);
        end else if (f3_s == 3'b101) begin
          raw_s.alu_op = instr_i[30] ? ALU_SRA : ALU_SRL;
          ill_s        = (f7_s != 7'b0000000) && (f7_s != 7'b0100000);
        end else begin
          raw_s.alu_op = alu_from_f3(f3_s, 1'b0);
        end
      end
      OPC_LOAD: begin
        raw_s.reg_wr = 1'b1;
        raw_s.sel_a  = 1'b1;
        raw_s.sel_b  = 1'b1;
        raw_s.rd_en  = 1'b1;
        raw_s.wb_sel = WB_MEM;
        raw_s.mask   = f3_s;
        u1_s         = 1'b1;
        ill_s        = (f3_s == 3'b011) || (f3_s == 3'b110) || (f3_s == 3'b111);
      end
      OPC_STORE: begin
        raw_s.wr_en = 1'b1;
        raw_s.sel_a = 1'b1;
        raw_s.sel_b = 1'b1;
        raw_s.mask  = f3_s;
        u1_s        = 1'b1;
        u2_s        = 1'b1;
        ill_s       = f3_s[2] || (f3_s == 3'b011);
      end
      OPC_BRANCH: begin
        raw_s.br_type = f3_s;
        raw_s.sel_b   = 1'b1;
        u1_s          = 1'b1;
        u2_s          = 1'b1;
        ill_s         = (f3_s == 3'b010) || (f3_s == 3'b011);
      end
      OPC_JAL: begin
        raw_s.reg_wr = 1'b1;
        raw_s.sel_b  = 1'b1;
        raw_s.wb_sel = WB_PC4;
      end
      OPC_JALR: begin
        raw_s.reg_wr  = 1'b1;
        raw_s.sel_a   = 1'b1;
        raw_s.sel_b   = 1'b1;
        raw_s.wb_sel  = WB_PC4;
        raw_s.is_jalr = 1'b1;
        u1_s          = 1'b1;
        ill_s         = (f3_s != 3'b000);
      end
      // LUI: sel_A=1 with execute forcing operand A to zero
      OPC_LUI: begin
        raw_s.reg_wr = 1'b1;
        raw_s.sel_a  = 1'b1;
        raw_s.sel_b  = 1'b1;
      end
      OPC_AUIPC: begin
        raw_s.reg_wr = 1'b1;
        raw_s.sel_b  = 1'b1;
      end
      default: begin
        ill_s = 1'b1;
      end
    endcase
  end

  // Illegal encodings keep only their register fields and the flag
  always_comb begin
    ctrl_o     = raw_s;
    uses_rs1_o = u1_s;
    uses_rs2_o = u2_s;
    if (ill_s) begin
      ctrl_o          = '0;
      ctrl_o.illegal  = 1'b1;
      ctrl_o.rd_addr  = raw_s.rd_addr;
      ctrl_o.rs1_addr = raw_s.rs1_addr;
      ctrl_o.rs2_addr = raw_s.rs2_addr;
      uses_rs1_o      = 1'b0;
      uses_rs2_o      = 1'b0;
    end else begin
      ctrl_o.illegal = 1'b0;
    end
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Registered decode stage: ID/EX output register with valid/ready flow control,
// load-use bubble insertion, multicycle-divide issue block and branch flush.
module decode_ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter bit EN_M        = 1'b1,
  parameter int DIV_LATENCY = 8,
  parameter int ALU_OP_W    = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  decode_ctrl_pipe_if.slave bus
);

  localparam int CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;

  ctrl_t            dec_s;
  logic             uses_rs1_s;
  logic             uses_rs2_s;
  ctrl_t            out_q, out_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             hazard_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             xfer_s;

  ctrl_decode #(.EN_M(EN_M)) u_dec (
    .instr_i    (bus.instruction),
    .ctrl_o     (dec_s),
    .uses_rs1_o (uses_rs1_s),
    .uses_rs2_o (uses_rs2_s)
  );

  assign hazard_s = valid_q && is_load(out_q) && (out_q.rd_addr != 5'd0) &&
                    ((uses_rs1_s && dec_s.rs1_addr == out_q.rd_addr) ||
                     (uses_rs2_s && dec_s.rs2_addr == out_q.rd_addr));

  assign in_ready_s = reset_n && (!valid_q || bus.out_ready) && !hazard_s &&
                      (div_q == '0) && !bus.flush;
  assign accept_s   = bus.in_valid && in_ready_s;
  // The held instruction is the one a flush kills, so it never counts as issued
  assign xfer_s     = valid_q && bus.out_ready && !bus.flush;

  // Output register and divide counter next state
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    div_d   = div_q;
    if (bus.flush) begin
      out_d   = '0;
      valid_d = 1'b0;
    end else if (accept_s) begin
      out_d   = dec_s;
      valid_d = 1'b1;
    end else if (xfer_s) begin
      out_d   = '0;
      valid_d = 1'b0;
    end else begin
      out_d   = out_q;
    end
    if (xfer_s && is_div(out_q)) begin
      div_d = CNT_W'(DIV_LATENCY - 1);
    end else if (div_q != '0) begin
      div_d = div_q - CNT_W'(1);
    end else begin
      div_d = div_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      div_q   <= '0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      div_q   <= div_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = valid_q;
  assign bus.alu_op    = ALU_OP_W'(out_q.alu_op);
  assign bus.mask      = out_q.mask;
  assign bus.br_type   = out_q.br_type;
  assign bus.reg_wr    = out_q.reg_wr;
  assign bus.sel_A     = out_q.sel_a;
  assign bus.sel_B     = out_q.sel_b;
  assign bus.rd_en     = out_q.rd_en;
  assign bus.wr_en     = out_q.wr_en;
  assign bus.wb_sel    = out_q.wb_sel;
  assign bus.is_jalr   = out_q.is_jalr;
  assign bus.rd_addr   = out_q.rd_addr;
  assign bus.rs1_addr  = out_q.rs1_addr;
  assign bus.rs2_addr  = out_q.rs2_addr;
  assign bus.illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench for decode_ctrl_pipe: one M-enabled instance for the main
// scenarios and one with EN_M=0 for the illegal-M check.
module tb_decode_ctrl_pipe;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  decode_ctrl_pipe_if #(.ALU_OP_W(5)) bus  ();
  decode_ctrl_pipe_if #(.ALU_OP_W(5)) bus2 ();

  decode_ctrl_pipe #(.EN_M(1'b1), .DIV_LATENCY(8), .ALU_OP_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  decode_ctrl_pipe #(.EN_M(1'b0), .DIV_LATENCY(8), .ALU_OP_W(5)) dut_nom (
    .clk(clk), .reset_n(reset_n), .bus(bus2.slave)
  );

  localparam logic [31:0] I_ADD    = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] I_LW     = 32'h0000A283; // lw x5,0(x1)
  localparam logic [31:0] I_ADD_DP = 32'h00228333; // add x6,x5,x2
  localparam logic [31:0] I_ADD_ND = 32'h00238333; // add x6,x7,x2
  localparam logic [31:0] I_DIV    = 32'h0220C233; // div x4,x1,x2
  localparam logic [31:0] I_SRAI   = 32'h4030D093; // srai x1,x1,3
  localparam logic [31:0] I_LUI    = 32'h12345537; // lui x10,0x12345
  localparam logic [31:0] I_AUIPC  = 32'h00001597; // auipc x11,1
  localparam logic [31:0] I_JALR   = 32'h000280E7; // jalr x1,0(x5)
  localparam logic [31:0] I_SW     = 32'h0020A023; // sw x2,0(x1)
  localparam logic [31:0] I_BAD    = 32'h0000007F;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.in_valid = 1'b0; bus.instruction = 32'h0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.instruction = 32'h0; bus2.flush = 1'b0; bus2.out_ready = 1'b1;
    #3;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %0b want 0", bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %0b want 0", bus.in_ready); end
    vectors++; if (bus.reg_wr !== 1'b0 || bus.alu_op !== 5'd0 || bus.illegal !== 1'b0) begin
      miscompares++; $display("FAIL rst_ctrl: reg_wr=%0b alu_op=%0d illegal=%0b want all 0", bus.reg_wr, bus.alu_op, bus.illegal); end
    #10 reset_n = 1'b1;
    tick();
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready: got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_add();
    bus.in_valid = 1'b1; bus.instruction = I_ADD; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL add_valid: got %0b want 1", bus.out_valid); end
    vectors++; if (bus.alu_op !== 5'd0 || bus.reg_wr !== 1'b1 || bus.sel_A !== 1'b1 || bus.sel_B !== 1'b0) begin
      miscompares++; $display("FAIL add_ctrl: alu_op=%0d reg_wr=%0b sel_A=%0b sel_B=%0b want 0 1 1 0", bus.alu_op, bus.reg_wr, bus.sel_A, bus.sel_B); end
    vectors++; if (bus.rd_addr !== 5'd3 || bus.rs1_addr !== 5'd1 || bus.rs2_addr !== 5'd2) begin
      miscompares++; $display("FAIL add_regs: rd=%0d rs1=%0d rs2=%0d want 3 1 2", bus.rd_addr, bus.rs1_addr, bus.rs2_addr); end
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL add_drain: got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_load_use();
    bus.in_valid = 1'b1; bus.instruction = I_LW;
    tick();
    vectors++; if (bus.rd_en !== 1'b1 || bus.wb_sel !== 2'd1 || bus.mask !== 3'd2 || bus.rd_addr !== 5'd5) begin
      miscompares++; $display("FAIL lw_ctrl: rd_en=%0b wb_sel=%0d mask=%0d rd=%0d want 1 1 2 5", bus.rd_en, bus.wb_sel, bus.mask, bus.rd_addr); end
    bus.instruction = I_ADD_DP;
    #1;
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL lu_hazard_ready: got %0b want 0", bus.in_ready); end
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL lu_bubble: got %0b want 0", bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL lu_after_bubble_ready: got %0b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    vectors++; if (bus.out_valid !== 1'b1 || bus.rd_addr !== 5'd6 || bus.rs1_addr !== 5'd5) begin
      miscompares++; $display("FAIL lu_dep_issue: valid=%0b rd=%0d rs1=%0d want 1 6 5", bus.out_valid, bus.rd_addr, bus.rs1_addr); end
    tick();
    bus.in_valid = 1'b1; bus.instruction = I_LW;
    tick();
    bus.instruction = I_ADD_ND;
    #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL nolu_ready: got %0b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    vectors++; if (bus.out_valid !== 1'b1 || bus.rs1_addr !== 5'd7) begin
      miscompares++; $display("FAIL nolu_issue: valid=%0b rs1=%0d want 1 7", bus.out_valid, bus.rs1_addr); end
    tick();
  endtask

  task automatic test_div();
    int cnt;
    bus.in_valid = 1'b1; bus.instruction = I_DIV;
    tick();
    bus.in_valid = 1'b0;
    vectors++; if (bus.alu_op !== 5'd14 || bus.reg_wr !== 1'b1 || bus.illegal !== 1'b0) begin
      miscompares++; $display("FAIL div_ctrl: alu_op=%0d reg_wr=%0b illegal=%0b want 14 1 0", bus.alu_op, bus.reg_wr, bus.illegal); end
    tick();
    cnt = 0;
    while (bus.in_ready === 1'b0 && cnt < 20) begin
      cnt++;
      bus.flush = (cnt == 2);
      tick();
      bus.flush = 1'b0;
      #1;
    end
    vectors++; if (cnt !== 7) begin miscompares++; $display("FAIL div_block_cycles: got %0d want 7", cnt); end
  endtask

  task automatic test_no_m();
    bus2.in_valid = 1'b1; bus2.instruction = I_DIV;
    tick();
    bus2.in_valid = 1'b0;
    vectors++; if (bus2.out_valid !== 1'b1 || bus2.illegal !== 1'b1) begin
      miscompares++; $display("FAIL nom_illegal: valid=%0b illegal=%0b want 1 1", bus2.out_valid, bus2.illegal); end
    vectors++; if (bus2.alu_op !== 5'd0 || bus2.reg_wr !== 1'b0 || bus2.sel_A !== 1'b0) begin
      miscompares++; $display("FAIL nom_ctrl: alu_op=%0d reg_wr=%0b sel_A=%0b want 0 0 0", bus2.alu_op, bus2.reg_wr, bus2.sel_A); end
    bus.in_valid = 1'b1; bus.instruction = I_BAD;
    tick();
    bus.in_valid = 1'b0;
    vectors++; if (bus.out_valid !== 1'b1 || bus.illegal !== 1'b1 || bus.reg_wr !== 1'b0) begin
      miscompares++; $display("FAIL bad_opcode: valid=%0b illegal=%0b reg_wr=%0b want 1 1 0", bus.out_valid, bus.illegal, bus.reg_wr); end
    tick();
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.instruction = I_SRAI;
    tick();
    bus.instruction = I_ADD;
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.alu_op !== 5'd6 || bus.rd_addr !== 5'd1) begin
        miscompares++; $display("FAIL stall_hold[%0d]: ready=%0b valid=%0b alu_op=%0d rd=%0d want 0 1 6 1", i, bus.in_ready, bus.out_valid, bus.alu_op, bus.rd_addr); end
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    vectors++; if (bus.out_valid !== 1'b1 || bus.alu_op !== 5'd0 || bus.rd_addr !== 5'd3) begin
      miscompares++; $display("FAIL stall_release: valid=%0b alu_op=%0d rd=%0d want 1 0 3", bus.out_valid, bus.alu_op, bus.rd_addr); end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.in_valid = 1'b1; bus.instruction = I_LUI;
    tick();
    bus.instruction = I_AUIPC;
    vectors++; if (bus.reg_wr !== 1'b1 || bus.sel_A !== 1'b1 || bus.sel_B !== 1'b1 || bus.alu_op !== 5'd0 || bus.wb_sel !== 2'd0) begin
      miscompares++; $display("FAIL lui: reg_wr=%0b sel_A=%0b sel_B=%0b alu_op=%0d wb_sel=%0d want 1 1 1 0 0", bus.reg_wr, bus.sel_A, bus.sel_B, bus.alu_op, bus.wb_sel); end
    tick();
    bus.instruction = I_JALR;
    vectors++; if (bus.out_valid !== 1'b1 || bus.reg_wr !== 1'b1 || bus.sel_A !== 1'b0 || bus.sel_B !== 1'b1 || bus.rd_addr !== 5'd11) begin
      miscompares++; $display("FAIL auipc: valid=%0b reg_wr=%0b sel_A=%0b sel_B=%0b rd=%0d want 1 1 0 1 11", bus.out_valid, bus.reg_wr, bus.sel_A, bus.sel_B, bus.rd_addr); end
    tick();
    bus.instruction = I_SW;
    vectors++; if (bus.wb_sel !== 2'd2 || bus.is_jalr !== 1'b1 || bus.sel_A !== 1'b1 || bus.reg_wr !== 1'b1) begin
      miscompares++; $display("FAIL jalr: wb_sel=%0d is_jalr=%0b sel_A=%0b reg_wr=%0b want 2 1 1 1", bus.wb_sel, bus.is_jalr, bus.sel_A, bus.reg_wr); end
    tick();
    bus.in_valid = 1'b0;
    vectors++; if (bus.rd_en !== 1'b0 || bus.wr_en !== 1'b1 || bus.mask !== 3'd2 || bus.reg_wr !== 1'b0) begin
      miscompares++; $display("FAIL store: rd_en=%0b wr_en=%0b mask=%0d reg_wr=%0b want 0 1 2 0", bus.rd_en, bus.wr_en, bus.mask, bus.reg_wr); end
    tick();
  endtask

  task automatic test_flush();
    bus.in_valid = 1'b1; bus.instruction = I_ADD; bus.flush = 1'b1;
    #1;
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_ready: got %0b want 0", bus.in_ready); end
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_no_accept: got %0b want 0", bus.out_valid); end
    bus.flush = 1'b0;
    tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.rd_addr !== 5'd3) begin
      miscompares++; $display("FAIL flush_resubmit: valid=%0b rd=%0d want 1 3", bus.out_valid, bus.rd_addr); end
    bus.instruction = I_SRAI; bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0; bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    vectors++; if (bus.out_valid !== 1'b0 || bus.alu_op !== 5'd0 || bus.reg_wr !== 1'b0) begin
      miscompares++; $display("FAIL flush_kill_held: valid=%0b alu_op=%0d reg_wr=%0b want 0 0 0", bus.out_valid, bus.alu_op, bus.reg_wr); end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.in_valid = 1'b1; bus.instruction = I_DIV;
    tick();
    bus.instruction = I_ADD;
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    tick();
    tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      miscompares++; $display("FAIL mid_pre: valid=%0b ready=%0b want 1 0", bus.out_valid, bus.in_ready); end
    #2 reset_n = 1'b0;
    #1;
    vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.reg_wr !== 1'b0) begin
      miscompares++; $display("FAIL mid_async: valid=%0b ready=%0b reg_wr=%0b want 0 0 0", bus.out_valid, bus.in_ready, bus.reg_wr); end
    bus.out_ready = 1'b1;
    #2 reset_n = 1'b1;
    tick();
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_release_ready: got %0b want 1", bus.in_ready); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_add();
    test_load_use();
    test_div();
    test_no_m();
    test_stall();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_pipe.md
Name: decode_ctrl_pipe

Overview:
Registered, handshaked successor to the combinational instruction controller; sits between the fetch/IF-ID latch and execute.
- Decodes one RV32I instruction per cycle, with optional RV32M, into the existing control bundle plus register addresses.
- Holds the result in an output (ID/EX) register with valid/ready flow control.
- Inserts load-use bubbles, blocks issue while a multicycle divide occupies execute, and honours branch flush.
- Adds LUI/AUIPC/JALR decode, an illegal flag, and corrected srai detection (instruction[30]).

Parameters:
EN_M, 1, enable RV32M decode (funct7 0000001 on opcode 0110011); 0 makes those encodings illegal
DIV_LATENCY, 8, execute cycles a div/divu/rem/remu occupies; 1 means no issue block
ALU_OP_W, 5, alu_op width (encodings 0..17)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction present
in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
instruction  in  32  raw instruction
flush  in  1  branch/jump taken in execute; kill the younger instruction
out_valid  out  1  output register holds a valid decoded instruction
out_ready  in  1  execute accepts; transfer when out_valid && out_ready
alu_op  out  ALU_OP_W  0 add, 1 sll, 2 slt, 3 sltu, 4 xor, 5 srl, 6 sra, 7 or, 8 and, 9 sub, 10 mul, 11 mulh, 12 mulhsu, 13 mulhu, 14 div, 15 divu, 16 rem, 17 remu
mask  out  3  load/store func3
br_type  out  3  branch func3
reg_wr, sel_A, sel_B, rd_en, wr_en  out  1 each  as the existing controller; sel_A=0 selects PC
wb_sel  out  2  0 ALU, 1 memory, 2 PC+4
is_jalr  out  1  jump target is rs1+imm
rd_addr, rs1_addr, rs2_addr  out  5 each  instruction[11:7], [19:15], [24:20]
illegal  out  1  unknown opcode/funct, or M op with EN_M=0

Behaviour:
Reset (async, reset_n low):
- out_valid=0, all control outputs 0, div counter 0.
- in_ready=0 while in reset.

Decode (combinational, then registered on accept): existing R/I/load/store/branch/JAL mappings retained, plus:
- LUI: reg_wr=1, sel_A=1, sel_B=1, alu_op=0. Execute supplies zero as operand A.
- AUIPC: reg_wr=1, sel_A=0, sel_B=1, alu_op=0.
- JALR: reg_wr=1, sel_A=1, sel_B=1, wb_sel=2, is_jalr=1.
- srai/sra select on instruction[30]=1; sub likewise.
- Store: rd_en=0. The old rd_en=1 on stores is dropped.
- Illegal encodings: all control 0, illegal=1, still issued with out_valid=1.

Latency and handshake:
- Latency is 1 cycle: accept at edge N, outputs valid after edge N.
- in_ready = (!out_valid || out_ready) && !hazard && div_cnt==0 && !flush.
- While out_valid && !out_ready, all outputs hold stable.
- On transfer with no new accept, out_valid goes to 0 next edge.

Load-use hazard:
- hazard = out_valid && out_is_load && out_rd!=0 && ((uses_rs1 && rs1==out_rd) || (uses_rs2 && rs2==out_rd)).
- uses_rs1 covers R, I, load, store, branch, JALR. uses_rs2 covers R, store, branch.
- Effect: the load transfers, one bubble is issued (out_valid=0), and the dependent instruction is accepted the following cycle. Exactly one bubble per hazard.

Divide block:
- When a transferring op has alu_op 14..17 (EN_M=1), div_cnt loads DIV_LATENCY-1.
- div_cnt decrements each cycle until 0; in_ready=0 while div_cnt!=0.
- flush does not clear div_cnt.

Flush:
- At the next edge, out_valid=0 and the output register is cleared.
- No accept occurs in a flush cycle.
- Flush overrides hazard, accept and out_ready.

Decomposition:
- Package ctrl_pkg: opcode localparams, alu_op enum (5-bit), wb_sel enum, packed struct ctrl_t holding all control fields and register addresses, and is_load/is_div helper functions.
- Sub-module ctrl_decode: purely combinational instruction -> ctrl_t, parameter EN_M.
- decode_ctrl_pipe adds the output register, hazard logic, div counter and handshake.

Test Plan:
- Reset then add x3,x1,x2 (0x002081B3) with out_ready=1 -> next cycle out_valid=1, alu_op=0, reg_wr=1, sel_A=1, rd_addr=3.
- lw x5,0(x1) followed by add x6,x5,x2 -> lw issues, one cycle out_valid=0, add issues the next cycle; no bubble if the add uses x7 instead.
- div x4,x1,x2 (0x0220C233) with EN_M=1, DIV_LATENCY=8 -> in_ready low 7 cycles after transfer; with EN_M=0 -> illegal=1, all control 0.
- out_ready=0 for 3 cycles holding srai x1,x1,3 (0x4030D093) -> alu_op=6 stable, in_ready=0, no new accept.
- flush asserted with in_valid=1 -> out_valid=0 next cycle, instruction not consumed; resubmitted instruction accepted the cycle after.
- reset_n pulsed low mid-stream with div_cnt=5 -> out_valid=0 and in_ready=0 immediately (asynchronously); div_cnt=0, so in_ready=1 on the first cycle after release.
